// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: IDLE -> REQ -> ISSUE loop with one outstanding read.
// Define FETCH_TIMEOUT_EN to build the REQ-phase timeout counter and sticky fetch_err.
module fetch_sequencer #(
  parameter int PC_W      = 12,
  parameter int TO_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            eneable,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [7:0]      mem_data,
  output logic [3:0]      instr,
  output logic [3:0]      oprnd,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            load_pc,
  input  logic [PC_W-1:0] load_addr,
  output logic [PC_W-1:0] pc,
  output logic            fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, ISSUE} state_t;
  state_t state;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);
  logic [7:0] to_cnt;
`endif

  // pc only moves on an ack or a taken jump, so it is the fetch address directly
  assign mem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      instr       <= '0;
      oprnd       <= '0;
      mem_req     <= 1'b0;
      instr_valid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      fetch_err   <= 1'b0;
      to_cnt      <= '0;
`endif
    end else if (eneable) begin
      case (state)
        IDLE: begin
          state   <= REQ;
          mem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
          to_cnt  <= '0;
`endif
        end
        REQ: begin
          if (mem_ack) begin
            instr       <= mem_data[7:4];
            oprnd       <= mem_data[3:0];
            pc          <= pc + PC_W'(1);
            state       <= ISSUE;
            mem_req     <= 1'b0;
            instr_valid <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            to_cnt      <= '0;
          end else if (to_cnt == TO_LAST) begin
            // stay in REQ at the same pc: the request simply stays up as a retry
            fetch_err   <= 1'b1;
            to_cnt      <= '0;
          end else begin
            to_cnt      <= to_cnt + 8'd1;
`endif
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            mem_req     <= 1'b1;
            state       <= REQ;
`ifdef FETCH_TIMEOUT_EN
            to_cnt      <= '0;
`endif
            if (load_pc) pc <= load_addr;
          end
        end
        default: begin
          state       <= IDLE;
          mem_req     <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

`ifndef FETCH_TIMEOUT_EN
  assign fetch_err = 1'b0;
`endif

endmodule
